// File: rtl/ibex_pkg.sv
// Shared CSR definitions: operation/address enums, controller states and the
// read-only / debug-range address classifier used by the CSR logic.
package ibex_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MSTATUS  = 12'h300,
        CSR_MSCRATCH = 12'h340,
        CSR_DCSR     = 12'h7B0,
        CSR_DPC      = 12'h7B1,
        CSR_MHARTID  = 12'hF14
    } csr_num_e;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_READ,
        CTRL_WRITE,
        CTRL_RESP
    } csr_ctrl_state_e;

    // The top two address bits set to 2'b11 mark a read-only CSR.
    function automatic logic csr_addr_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

    function automatic logic csr_addr_debug(input logic [11:0] addr);
        return addr[11:4] == 8'h7B;
    endfunction

endpackage

// File: rtl/ibex_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module ibex_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_csr_access_ctrl.sv
// CSR access initiator: runs read-modify-write sequences against the CSR register
// file, applies privilege checks and reports the old value plus access statistics.
module ibex_csr_access_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned CntWidth    = 16,
    parameter bit          DbgCsrCheck = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [11:0]         req_addr_i,
    input  logic [1:0]          req_op_i,
    input  logic [31:0]         req_wdata_i,
    input  logic                debug_mode_i,
    output logic [11:0]         csr_addr_o,
    output logic                csr_rd_en_o,
    input  logic [31:0]         csr_rdata_i,
    input  logic                csr_illegal_i,
    output logic                csr_we_o,
    output logic [31:0]         csr_wdata_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_illegal_o,
    output logic [CntWidth-1:0] acc_cnt_o,
    output logic [CntWidth-1:0] ill_cnt_o
);

    csr_ctrl_state_e state_q, state_d;

    logic [11:0] addr_q;
    csr_op_e     op_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q, old_d;
    logic        ill_q, ill_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;

    logic        write_intent;
    logic        illegal_now;
    logic [31:0] new_val;
    logic        req_accept;
    logic        rsp_handshake;

    assign req_accept    = (state_q == CTRL_IDLE) && req_valid_i;
    assign rsp_handshake = (state_q == CTRL_RESP) && rsp_ready_i;

    // SET/CLEAR with a zero operand are pure reads and must not trip the read-only check.
    always_comb begin
        write_intent = 1'b0;
        new_val      = csr_rdata_i;
        unique case (op_q)
            CSR_OP_WRITE: begin
                write_intent = 1'b1;
                new_val      = wdata_q;
            end
            CSR_OP_SET: begin
                write_intent = (wdata_q != '0);
                new_val      = csr_rdata_i | wdata_q;
            end
            CSR_OP_CLEAR: begin
                write_intent = (wdata_q != '0);
                new_val      = csr_rdata_i & ~wdata_q;
            end
            default: begin
                write_intent = 1'b0;
                new_val      = csr_rdata_i;
            end
        endcase

        illegal_now = csr_illegal_i
                    | (write_intent && csr_addr_read_only(addr_q))
                    | (DbgCsrCheck && csr_addr_debug(addr_q) && !debug_mode_i);
    end

    always_comb begin
        state_d     = state_q;
        old_d       = old_q;
        ill_d       = ill_q;
        csr_wdata_d = csr_wdata_q;
        unique case (state_q)
            CTRL_IDLE: begin
                if (req_valid_i) begin
                    state_d = CTRL_READ;
                end
            end
            CTRL_READ: begin
                old_d = illegal_now ? '0 : csr_rdata_i;
                ill_d = illegal_now;
                if (write_intent && !illegal_now) begin
                    state_d     = CTRL_WRITE;
                    csr_wdata_d = new_val;
                end else begin
                    state_d = CTRL_RESP;
                end
            end
            CTRL_WRITE: begin
                state_d = CTRL_RESP;
            end
            CTRL_RESP: begin
                if (rsp_ready_i) begin
                    state_d = CTRL_IDLE;
                end
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CTRL_IDLE;
            addr_q      <= '0;
            op_q        <= CSR_OP_READ;
            wdata_q     <= '0;
            old_q       <= '0;
            ill_q       <= 1'b0;
            csr_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            old_q       <= old_d;
            ill_q       <= ill_d;
            csr_wdata_q <= csr_wdata_d;
            if (req_accept) begin
                addr_q  <= req_addr_i;
                op_q    <= csr_op_e'(req_op_i);
                wdata_q <= req_wdata_i;
            end
        end
    end

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign req_ready_o   = (state_q == CTRL_IDLE) && !rst;
    assign csr_rd_en_o   = (state_q == CTRL_READ);
    assign csr_we_o      = (state_q == CTRL_WRITE);
    assign csr_addr_o    = addr_q;
    assign csr_wdata_o   = csr_wdata_q;
    assign rsp_valid_o   = (state_q == CTRL_RESP);
    assign rsp_rdata_o   = old_q;
    assign rsp_illegal_o = ill_q;

    ibex_sat_counter #(
        .Width (CntWidth)
    ) u_acc_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (rsp_handshake),
        .clear_i (1'b0),
        .cnt_o   (acc_cnt_o)
    );

    ibex_sat_counter #(
        .Width (CntWidth)
    ) u_ill_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (rsp_handshake && ill_q),
        .clear_i (1'b0),
        .cnt_o   (ill_cnt_o)
    );

endmodule

// File: tb/tb_ibex_csr_access_ctrl.sv
// Self-checking bench for ibex_csr_access_ctrl: directed scenarios plus randomized
// traffic against a behavioural CSR model, with a 2-bit counter instance for saturation.
module tb_ibex_csr_access_ctrl;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o;
    logic [11:0] req_addr_i;
    logic [1:0]  req_op_i;
    logic [31:0] req_wdata_i;
    logic        debug_mode_i;
    logic [11:0] csr_addr_o;
    logic        csr_rd_en_o;
    logic [31:0] csr_rdata_i;
    logic        csr_illegal_i;
    logic        csr_we_o;
    logic [31:0] csr_wdata_o;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_illegal_o;
    logic [15:0] acc_cnt_o, ill_cnt_o;

    logic        s_req_ready, s_rd_en, s_we, s_rsp_valid, s_rsp_illegal;
    logic [11:0] s_csr_addr;
    logic [31:0] s_csr_rdata, s_csr_wdata, s_rsp_rdata;
    logic [1:0]  s_acc_cnt, s_ill_cnt;

    // Register file model: combinational read, written on the DUT strobe or by preload.
    logic [31:0] rfMem [4096];
    logic [31:0] expMem [4096];
    logic        preEn = 1'b0;
    logic [11:0] preAddr = '0;
    logic [31:0] preData = '0;

    int checks = 0;
    int errors = 0;
    int accCnt = 0;
    int illCnt = 0;

    logic        expIll, expWrite;
    logic [31:0] expRdata, expNew;
    int          expLat;

    int          obsLat, obsWeCnt, obsWeK;
    logic [31:0] obsWeData, obsRdata;
    logic [11:0] obsWeAddr, obsRdAddr;
    logic        obsReady, obsRdEn, obsIll, obsStable, obsIdle, obsBusyReady;

    always #5 clk = ~clk;

    assign csr_rdata_i = rfMem[csr_addr_o];
    assign s_csr_rdata = rfMem[s_csr_addr];

    always @(posedge clk) begin
        if (preEn) rfMem[preAddr] <= preData;
        else if (csr_we_o) rfMem[csr_addr_o] <= csr_wdata_o;
    end

    ibex_csr_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_wdata_i(req_wdata_i),
        .debug_mode_i(debug_mode_i), .csr_addr_o(csr_addr_o), .csr_rd_en_o(csr_rd_en_o),
        .csr_rdata_i(csr_rdata_i), .csr_illegal_i(csr_illegal_i), .csr_we_o(csr_we_o),
        .csr_wdata_o(csr_wdata_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_illegal_o(rsp_illegal_o),
        .acc_cnt_o(acc_cnt_o), .ill_cnt_o(ill_cnt_o)
    );

    ibex_csr_access_ctrl #(.CntWidth(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(s_req_ready),
        .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_wdata_i(req_wdata_i),
        .debug_mode_i(debug_mode_i), .csr_addr_o(s_csr_addr), .csr_rd_en_o(s_rd_en),
        .csr_rdata_i(s_csr_rdata), .csr_illegal_i(csr_illegal_i), .csr_we_o(s_we),
        .csr_wdata_o(s_csr_wdata), .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(s_rsp_rdata), .rsp_illegal_o(s_rsp_illegal),
        .acc_cnt_o(s_acc_cnt), .ill_cnt_o(s_ill_cnt)
    );

    function automatic int satv(input int c, input int m);
        return (c > m) ? m : c;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        preEn = 1'b1; preAddr = a; preData = d;
        @(negedge clk);
        preEn = 1'b0;
        expMem[a] = d;
    endtask

    // Reference rules: write intent, privilege checks and new value from plain arithmetic.
    task automatic modelPredict(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                                input logic dbg, input logic rfIll);
        logic        intent;
        logic [31:0] old;
        old    = expMem[a];
        intent = (op == 2'd1) || ((op == 2'd2 || op == 2'd3) && wd != 32'd0);
        expIll = rfIll || (intent && a >= 12'hC00) || (a >= 12'h7B0 && a <= 12'h7BF && !dbg);
        expRdata = expIll ? 32'd0 : old;
        expWrite = intent && !expIll;
        case (op)
            2'd1:    expNew = wd;
            2'd2:    expNew = old | wd;
            2'd3:    expNew = old & ~wd;
            default: expNew = old;
        endcase
        expLat = expWrite ? 3 : 2;
    endtask

    task automatic modelCommit(input logic [11:0] a);
        if (expWrite) expMem[a] = expNew;
        accCnt++;
        if (expIll) illCnt++;
    endtask

    task automatic runOp(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                         input logic dbg, input logic rfIll, input int hold);
        logic [31:0] r0;
        logic        i0;
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = a; req_op_i = op; req_wdata_i = wd;
        debug_mode_i = dbg; csr_illegal_i = rfIll; rsp_ready_i = (hold == 0);
        obsReady = req_ready_o;
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_addr_i = 12'($urandom); req_op_i = 2'($urandom); req_wdata_i = $urandom;
        obsRdEn = csr_rd_en_o; obsRdAddr = csr_addr_o;
        obsLat = 0; obsWeCnt = 0; obsWeK = 0; obsWeData = '0; obsWeAddr = '0; obsBusyReady = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (csr_we_o) begin
                obsWeCnt++; obsWeK = k; obsWeData = csr_wdata_o; obsWeAddr = csr_addr_o;
            end
            if (rsp_valid_o) begin
                obsLat = k;
                break;
            end
            obsBusyReady = obsBusyReady | req_ready_o;
            @(posedge clk); #1;
        end
        obsRdata = rsp_rdata_o; obsIll = rsp_illegal_o;
        r0 = rsp_rdata_o; i0 = rsp_illegal_o;
        obsStable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== r0 || rsp_illegal_o !== i0 || req_ready_o !== 1'b0)
                obsStable = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        obsIdle = req_ready_o && !rsp_valid_o;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b want 0", req_ready_o); end
        checks++; if ({rsp_valid_o, csr_rd_en_o, csr_we_o, rsp_illegal_o} !== 4'b0) begin errors++; $display("[TB] FAIL rst_strobes got %b want 0000", {rsp_valid_o, csr_rd_en_o, csr_we_o, rsp_illegal_o}); end
        checks++; if ({csr_addr_o, csr_wdata_o, rsp_rdata_o} !== 76'd0) begin errors++; $display("[TB] FAIL rst_data got %h %h %h want 0", csr_addr_o, csr_wdata_o, rsp_rdata_o); end
        checks++; if (acc_cnt_o !== 16'd0 || ill_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL rst_cnt got %0d %0d want 0 0", acc_cnt_o, ill_cnt_o); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready got %b want 1", req_ready_o); end
    endtask

    task automatic test_write_mscratch();
        preload(12'h340, 32'h12345678);
        modelPredict(12'h340, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0);
        runOp(12'h340, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        modelCommit(12'h340);
        checks++; if (obsReady !== 1'b1 || obsRdEn !== 1'b1 || obsRdAddr !== 12'h340) begin errors++; $display("[TB] FAIL mscr_read got rdy=%b rd=%b addr=%h want 1 1 340", obsReady, obsRdEn, obsRdAddr); end
        checks++; if (obsWeCnt !== 1 || obsWeK !== 2) begin errors++; $display("[TB] FAIL mscr_we got cnt=%0d at=%0d want 1 at 2", obsWeCnt, obsWeK); end
        checks++; if (obsWeData !== 32'hDEADBEEF || obsWeAddr !== 12'h340) begin errors++; $display("[TB] FAIL mscr_wdata got %h@%h want deadbeef@340", obsWeData, obsWeAddr); end
        checks++; if (obsRdata !== 32'h12345678 || obsIll !== 1'b0) begin errors++; $display("[TB] FAIL mscr_rsp got %h ill=%b want 12345678 0", obsRdata, obsIll); end
        checks++; if (obsLat !== 3 || obsIdle !== 1'b1) begin errors++; $display("[TB] FAIL mscr_lat got %0d idle=%b want 3 1", obsLat, obsIdle); end
        checks++; if (acc_cnt_o !== 16'd1 || rfMem[12'h340] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mscr_cnt got %0d mem=%h want 1 deadbeef", acc_cnt_o, rfMem[12'h340]); end
    endtask

    task automatic test_set_clear();
        preload(12'h300, 32'h1880);
        runOp(12'h300, 2'd2, 32'h8, 1'b0, 1'b0, 0);
        checks++; if (obsWeCnt !== 1 || obsWeData !== 32'h1888) begin errors++; $display("[TB] FAIL set_wdata got %0d x %h want 1 x 00001888", obsWeCnt, obsWeData); end
        checks++; if (obsRdata !== 32'h1880) begin errors++; $display("[TB] FAIL set_old got %h want 00001880", obsRdata); end
        preload(12'h300, 32'h1880);
        runOp(12'h300, 2'd3, 32'h80, 1'b0, 1'b0, 0);
        checks++; if (obsWeCnt !== 1 || obsWeData !== 32'h1800) begin errors++; $display("[TB] FAIL clr_wdata got %0d x %h want 1 x 00001800", obsWeCnt, obsWeData); end
        runOp(12'h300, 2'd2, 32'h0, 1'b0, 1'b0, 0);
        checks++; if (obsWeCnt !== 0 || obsLat !== 2) begin errors++; $display("[TB] FAIL set0 got we=%0d lat=%0d want 0 2", obsWeCnt, obsLat); end
        checks++; if (obsRdata !== 32'h1800) begin errors++; $display("[TB] FAIL set0_old got %h want 00001800", obsRdata); end
        expMem[12'h300] = 32'h1800;
        accCnt += 3;
    endtask

    task automatic test_read_only();
        preload(12'hF14, 32'h7);
        runOp(12'hF14, 2'd1, 32'h55, 1'b0, 1'b0, 0);
        checks++; if (obsIll !== 1'b1 || obsRdata !== 32'd0) begin errors++; $display("[TB] FAIL ro_wr got ill=%b %h want 1 0", obsIll, obsRdata); end
        checks++; if (obsWeCnt !== 0 || obsLat !== 2) begin errors++; $display("[TB] FAIL ro_we got we=%0d lat=%0d want 0 2", obsWeCnt, obsLat); end
        accCnt++; illCnt++;
        checks++; if (ill_cnt_o !== 16'(illCnt)) begin errors++; $display("[TB] FAIL ro_illcnt got %0d want %0d", ill_cnt_o, illCnt); end
        runOp(12'hF14, 2'd0, 32'h55, 1'b0, 1'b0, 0);
        accCnt++;
        checks++; if (obsIll !== 1'b0 || obsRdata !== 32'h7) begin errors++; $display("[TB] FAIL ro_rd got ill=%b %h want 0 7", obsIll, obsRdata); end
    endtask

    task automatic test_debug();
        preload(12'h7B0, 32'h40000003);
        runOp(12'h7B0, 2'd1, 32'h8003, 1'b0, 1'b0, 0);
        accCnt++; illCnt++;
        checks++; if (obsIll !== 1'b1 || obsWeCnt !== 0) begin errors++; $display("[TB] FAIL dbg_off got ill=%b we=%0d want 1 0", obsIll, obsWeCnt); end
        runOp(12'h7B0, 2'd1, 32'h8003, 1'b1, 1'b0, 0);
        accCnt++;
        expMem[12'h7B0] = 32'h8003;
        checks++; if (obsIll !== 1'b0 || obsWeCnt !== 1 || obsWeData !== 32'h8003) begin errors++; $display("[TB] FAIL dbg_on got ill=%b we=%0d %h want 0 1 8003", obsIll, obsWeCnt, obsWeData); end
        checks++; if (obsRdata !== 32'h40000003) begin errors++; $display("[TB] FAIL dbg_old got %h want 40000003", obsRdata); end
    endtask

    task automatic test_hold();
        modelPredict(12'h340, 2'd0, 32'h0, 1'b0, 1'b0);
        runOp(12'h340, 2'd0, 32'h0, 1'b0, 1'b0, 5);
        modelCommit(12'h340);
        checks++; if (obsStable !== 1'b1) begin errors++; $display("[TB] FAIL hold_stable got %b want 1", obsStable); end
        checks++; if (obsIdle !== 1'b1 || obsRdata !== expRdata) begin errors++; $display("[TB] FAIL hold_idle got %b %h want 1 %h", obsIdle, obsRdata, expRdata); end
        checks++; if (acc_cnt_o !== 16'(satv(accCnt, 65535))) begin errors++; $display("[TB] FAIL hold_cnt got %0d want %0d", acc_cnt_o, accCnt); end
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            logic [15:0] rdMask, weMask, vMask, expRd, expWe, expV;
            int interval, dropK;
            interval = (m == 0) ? 4 : 3;
            dropK    = (m == 0) ? 9 : 7;
            expRd = '0; expWe = '0; expV = '0;
            for (int j = 0; j < 3; j++) begin
                expRd[1 + j*interval] = 1'b1;
                if (m == 0) expWe[2 + j*interval] = 1'b1;
                expV[1 + j*interval + ((m == 0) ? 2 : 1)] = 1'b1;
                modelPredict(12'h340, (m == 0) ? 2'd1 : 2'd0, 32'h0BADF00D, 1'b0, 1'b0);
                modelCommit(12'h340);
            end
            @(negedge clk);
            req_valid_i = 1'b1; req_addr_i = 12'h340; req_op_i = (m == 0) ? 2'd1 : 2'd0;
            req_wdata_i = 32'h0BADF00D; debug_mode_i = 1'b0; csr_illegal_i = 1'b0; rsp_ready_i = 1'b1;
            @(posedge clk); #1;
            rdMask = '0; weMask = '0; vMask = '0;
            for (int k = 1; k <= 12; k++) begin
                rdMask[k] = csr_rd_en_o; weMask[k] = csr_we_o; vMask[k] = rsp_valid_o;
                if (k == dropK) req_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            rsp_ready_i = 1'b0;
            checks++; if (rdMask !== expRd) begin errors++; $display("[TB] FAIL b2b_rd%0d got %b want %b", m, rdMask, expRd); end
            checks++; if (weMask !== expWe) begin errors++; $display("[TB] FAIL b2b_we%0d got %b want %b", m, weMask, expWe); end
            checks++; if (vMask !== expV) begin errors++; $display("[TB] FAIL b2b_v%0d got %b want %b", m, vMask, expV); end
            checks++; if (acc_cnt_o !== 16'(satv(accCnt, 65535))) begin errors++; $display("[TB] FAIL b2b_cnt%0d got %0d want %0d", m, acc_cnt_o, accCnt); end
        end
        checks++; if (rfMem[12'h340] !== expMem[12'h340]) begin errors++; $display("[TB] FAIL b2b_mem got %h want %h", rfMem[12'h340], expMem[12'h340]); end
    endtask

    task automatic test_random();
        logic [11:0] pool [12] = '{12'h300, 12'h340, 12'h305, 12'hF14, 12'hF11, 12'h7B0,
                                   12'h7B2, 12'h7BF, 12'h7AF, 12'h7C0, 12'hC00, 12'h3A0};
        for (int i = 0; i < 40; i++) begin
            logic [11:0] a;
            logic [1:0]  op;
            logic [31:0] wd;
            logic        dbg, rfi;
            int          hold;
            a    = pool[$urandom_range(0, 11)];
            op   = 2'($urandom);
            wd   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            dbg  = 1'($urandom);
            rfi  = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(0, 2);
            modelPredict(a, op, wd, dbg, rfi);
            runOp(a, op, wd, dbg, rfi, hold);
            modelCommit(a);
            checks++; if (obsIll !== expIll || obsRdata !== expRdata) begin errors++; $display("[TB] FAIL rnd%0d_rsp got ill=%b %h want %b %h", i, obsIll, obsRdata, expIll, expRdata); end
            checks++; if (obsLat !== expLat || obsWeCnt !== (expWrite ? 1 : 0)) begin errors++; $display("[TB] FAIL rnd%0d_seq got lat=%0d we=%0d want %0d %0d", i, obsLat, obsWeCnt, expLat, expWrite ? 1 : 0); end
            if (expWrite) begin
                checks++; if (obsWeData !== expNew || obsWeAddr !== a) begin errors++; $display("[TB] FAIL rnd%0d_wr got %h@%h want %h@%h", i, obsWeData, obsWeAddr, expNew, a); end
            end
            checks++; if (obsRdEn !== 1'b1 || obsRdAddr !== a || obsBusyReady !== 1'b0 || obsIdle !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_ctl got rd=%b %h busy=%b idle=%b want 1 %h 0 1", i, obsRdEn, obsRdAddr, obsBusyReady, obsIdle, a); end
            if (hold > 0) begin
                checks++; if (obsStable !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_hold got %b want 1", i, obsStable); end
            end
            checks++; if (rfMem[a] !== expMem[a]) begin errors++; $display("[TB] FAIL rnd%0d_mem got %h want %h", i, rfMem[a], expMem[a]); end
            checks++; if (acc_cnt_o !== 16'(satv(accCnt, 65535)) || ill_cnt_o !== 16'(satv(illCnt, 65535))) begin errors++; $display("[TB] FAIL rnd%0d_cnt got %0d %0d want %0d %0d", i, acc_cnt_o, ill_cnt_o, accCnt, illCnt); end
            checks++; if (s_acc_cnt !== 2'(satv(accCnt, 3)) || s_ill_cnt !== 2'(satv(illCnt, 3))) begin errors++; $display("[TB] FAIL rnd%0d_sat got %0d %0d want %0d %0d", i, s_acc_cnt, s_ill_cnt, satv(accCnt, 3), satv(illCnt, 3)); end
        end
    endtask

    task automatic test_reset_mid();
        logic rspSeen;
        preload(12'h340, 32'h11112222);
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 12'h340; req_op_i = 2'd1; req_wdata_i = 32'hA5A5A5A5;
        debug_mode_i = 1'b0; csr_illegal_i = 1'b0; rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (csr_we_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_inwrite got %b want 1", csr_we_o); end
        rst = 1'b1;
        #1;
        checks++; if (csr_we_o !== 1'b0 || rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_strobe got we=%b v=%b want 0 0", csr_we_o, rsp_valid_o); end
        checks++; if (acc_cnt_o !== 16'd0 || ill_cnt_o !== 16'd0 || s_acc_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rstmid_cnt got %0d %0d %0d want 0 0 0", acc_cnt_o, ill_cnt_o, s_acc_cnt); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        rspSeen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            rspSeen = rspSeen | rsp_valid_o | csr_we_o;
        end
        rsp_ready_i = 1'b0;
        accCnt = 0; illCnt = 0;
        checks++; if (rspSeen !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_after got seen=%b rdy=%b want 0 1", rspSeen, req_ready_o); end
        checks++; if (rfMem[12'h340] !== 32'h11112222) begin errors++; $display("[TB] FAIL rstmid_mem got %h want 11112222", rfMem[12'h340]); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            runOp(12'hF14, 2'd1, 32'h1 + i, 1'b0, 1'b0, 0);
            accCnt++; illCnt++;
        end
        checks++; if (s_ill_cnt !== 2'd3 || s_acc_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat2 got ill=%0d acc=%0d want 3 3", s_ill_cnt, s_acc_cnt); end
        checks++; if (ill_cnt_o !== 16'd5 || acc_cnt_o !== 16'd5) begin errors++; $display("[TB] FAIL sat16 got ill=%0d acc=%0d want 5 5", ill_cnt_o, acc_cnt_o); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; req_op_i = '0; req_wdata_i = '0;
        debug_mode_i = 1'b0; csr_illegal_i = 1'b0; rsp_ready_i = 1'b0;
        preload(12'h300, 32'h0); preload(12'h340, 32'h0); preload(12'h305, 32'h100);
        preload(12'hF14, 32'h0); preload(12'hF11, 32'h602); preload(12'h7B0, 32'h0);
        preload(12'h7B2, 32'hCAFE); preload(12'h7BF, 32'h77); preload(12'h7AF, 32'h5);
        preload(12'h7C0, 32'h9); preload(12'hC00, 32'h1234); preload(12'h3A0, 32'h1F);
        test_reset();
        test_write_mscratch();
        test_set_clear();
        test_read_only();
        test_debug();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
